// File: rtl/ram_mp_init.sv
// Multi-port synchronous RAM with per-lane write masks, lowest-port-wins collision
// resolution, selectable read-during-write behaviour and a post-reset hardware clear.
module ram_mp_init #(
  parameter int unsigned     DATA     = 32,
  parameter int unsigned     DEPTH    = 16,
  parameter int unsigned     PORT     = 2,
  parameter int unsigned     BYTE     = 8,
  parameter int unsigned     OUTREG   = 0,
  parameter int unsigned     RDW_MODE = 0,
  parameter logic [DATA-1:0] INIT_VAL = '0,
  parameter int unsigned     ADDR     = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PORT-1:0]                en_,
  input  logic [PORT-1:0]                rw_,
  input  logic [PORT-1:0][ADDR-1:0]      addr,
  input  logic [PORT-1:0][DATA-1:0]      wdata,
  input  logic [PORT-1:0][DATA/BYTE-1:0] wmask,
  output logic [PORT-1:0][DATA-1:0]      rdata,
  output logic [PORT-1:0]                rvalid,
  output logic                           busy,
  output logic                           coll
);

  localparam int unsigned LANE = DATA / BYTE;

  if (DATA % BYTE != 0) begin : gen_bad_lane
    $error("ram_mp_init: DATA must be a multiple of BYTE");
  end

  typedef enum logic [0:0] {StInit, StRun} state_e;

  logic [DATA-1:0] mem [DEPTH];

  state_e          state_q;
  logic [ADDR-1:0] cnt_q;
  logic            busy_q;
  logic            coll_q;
  logic            coll_d;
  logic            run;

  logic [PORT-1:0]           in_range;
  logic [PORT-1:0]           wr_req;
  logic [PORT-1:0]           rd_req;
  logic [PORT-1:0][DATA-1:0] old_word;
  logic [PORT-1:0][DATA-1:0] new_word;
  logic [PORT-1:0][DATA-1:0] rd_word;

  logic [PORT-1:0]           rvalid1_q;
  logic [PORT-1:0][DATA-1:0] rdata1_q;

  // Clear sequencer: busy drops on the same edge that writes the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == StInit) begin
      cnt_q <= cnt_q + ADDR'(1);
      if (cnt_q == ADDR'(DEPTH - 1)) begin
        state_q <= StRun;
        busy_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    run    = (state_q == StRun);
    coll_d = 1'b0;
    for (int unsigned p = 0; p < PORT; p++) begin
      in_range[p] = (32'(addr[p]) < DEPTH);
      wr_req[p]   = run & ~en_[p] & ~rw_[p] & in_range[p];
      rd_req[p]   = run & ~en_[p] & rw_[p];
      old_word[p] = in_range[p] ? mem[addr[p]] : '0;
    end
    // Merged post-write word seen at each port's address; applying ports from the
    // highest index down lets the lowest-index writer win each lane.
    for (int unsigned p = 0; p < PORT; p++) begin
      new_word[p] = old_word[p];
      for (int q = int'(PORT) - 1; q >= 0; q--) begin
        for (int unsigned l = 0; l < LANE; l++) begin
          if (wr_req[q] && wmask[q][l] && (addr[q] == addr[p])) begin
            new_word[p][l*BYTE +: BYTE] = wdata[q][l*BYTE +: BYTE];
          end
        end
      end
      rd_word[p] = (RDW_MODE != 0) ? new_word[p] : old_word[p];
    end
    for (int unsigned p = 0; p < PORT; p++) begin
      for (int unsigned q = p + 1; q < PORT; q++) begin
        for (int unsigned l = 0; l < LANE; l++) begin
          if (wr_req[p] && wr_req[q] && (addr[p] == addr[q]) && wmask[p][l] && wmask[q][l]) begin
            coll_d = 1'b1;
          end
        end
      end
    end
  end

  // Every writer to a shared address stores the same merged word, so order is irrelevant.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= INIT_VAL;
    end
    for (int unsigned p = 0; p < PORT; p++) begin
      if (wr_req[p]) begin
        mem[addr[p]] <= new_word[p];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid1_q <= '0;
      rdata1_q  <= '0;
      coll_q    <= 1'b0;
    end else begin
      rvalid1_q <= rd_req;
      coll_q    <= coll_d;
      for (int unsigned p = 0; p < PORT; p++) begin
        if (rd_req[p]) begin
          rdata1_q[p] <= rd_word[p];
        end
      end
    end
  end

  if (OUTREG != 0) begin : gen_outreg
    logic [PORT-1:0]           rvalid2_q;
    logic [PORT-1:0][DATA-1:0] rdata2_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rvalid2_q <= '0;
        rdata2_q  <= '0;
      end else begin
        rvalid2_q <= rvalid1_q;
        for (int unsigned p = 0; p < PORT; p++) begin
          if (rvalid1_q[p]) begin
            rdata2_q[p] <= rdata1_q[p];
          end
        end
      end
    end

    assign rvalid = rvalid2_q;
    assign rdata  = rdata2_q;
  end else begin : gen_direct
    assign rvalid = rvalid1_q;
    assign rdata  = rdata1_q;
  end

  assign busy = busy_q;
  assign coll = coll_q;

endmodule

// File: tb/tb_ram_mp_init.sv
// Directed bench for ram_mp_init: one instance with latency 1 / old-data RDW, a second
// with output register / new-data RDW, both driven by the same stimulus.
module tb_ram_mp_init;

  logic                  clk;
  logic                  reset;
  logic [1:0]            en_;
  logic [1:0]            rw_;
  logic [1:0][3:0]       addr;
  logic [1:0][31:0]      wdata;
  logic [1:0][3:0]       wmask;

  logic [1:0][31:0]      rdata_a, rdata_b;
  logic [1:0]            rvalid_a, rvalid_b;
  logic                  busy_a, busy_b;
  logic                  coll_a, coll_b;

  int n_checks = 0;
  int n_errors = 0;

  ram_mp_init #(
    .DATA(32), .DEPTH(16), .PORT(2), .BYTE(8), .OUTREG(0), .RDW_MODE(0), .INIT_VAL(32'h0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .en_(en_), .rw_(rw_), .addr(addr), .wdata(wdata),
    .wmask(wmask), .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a), .coll(coll_a)
  );

  ram_mp_init #(
    .DATA(32), .DEPTH(16), .PORT(2), .BYTE(8), .OUTREG(1), .RDW_MODE(1), .INIT_VAL(32'h0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .en_(en_), .rw_(rw_), .addr(addr), .wdata(wdata),
    .wmask(wmask), .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b), .coll(coll_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_   = 2'b11;
    rw_   = 2'b11;
    wmask = '0;
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    en_[p]   = 1'b0;
    rw_[p]   = 1'b0;
    addr[p]  = a;
    wdata[p] = d;
    wmask[p] = m;
  endtask

  task automatic rd(input int p, input logic [3:0] a);
    en_[p]  = 1'b0;
    rw_[p]  = 1'b1;
    addr[p] = a;
  endtask

  initial begin
    reset = 1'b1;
    addr  = '0;
    wdata = '0;
    idle();
    cyc();
    cyc();
    check("reset_busy", 32'(busy_a), 32'h1);
    check("reset_rvalid", 32'(rvalid_a), 32'h0);
    check("reset_coll", 32'(coll_a), 32'h0);
    check("reset_rdata", rdata_a[1], 32'h0);

    // Clear takes exactly 16 cycles after release.
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check($sformatf("init_busy_%0d", i), 32'(busy_a), (i < 16) ? 32'h1 : 32'h0);
    end

    // 1: every word reads back as INIT_VAL, one read per cycle.
    for (int i = 0; i < 16; i++) begin
      rd(1, 4'(i));
      cyc();
      check($sformatf("t1_rvalid_%0d", i), 32'(rvalid_a), 32'h2);
      check($sformatf("t1_rdata_%0d", i), rdata_a[1], 32'h0);
    end
    idle();
    cyc();
    check("t1_rvalid_strobe", 32'(rvalid_a), 32'h0);

    // 2: partial-mask overwrite.
    wr(0, 4'd3, 32'hdeadbeef, 4'hf);
    cyc();
    wr(0, 4'd3, 32'h11223344, 4'b0101);
    cyc();
    idle();
    rd(1, 4'd3);
    cyc();
    idle();
    check("t2_rdata", rdata_a[1], 32'hde22be44);

    // 3: overlapping-lane collision, then disjoint lanes.
    wr(0, 4'd5, 32'haaaaaaaa, 4'b0011);
    wr(1, 4'd5, 32'h55555555, 4'b0110);
    cyc();
    check("t3_coll_set", 32'(coll_a), 32'h1);
    idle();
    rd(1, 4'd5);
    cyc();
    idle();
    check("t3_coll_pulse", 32'(coll_a), 32'h0);
    check("t3_merge", rdata_a[1], 32'h0055aaaa);
    wr(0, 4'd5, 32'haaaaaaaa, 4'b0011);
    wr(1, 4'd5, 32'h55555555, 4'b1100);
    cyc();
    check("t3_coll_disjoint", 32'(coll_a), 32'h0);
    idle();
    rd(1, 4'd5);
    cyc();
    idle();
    check("t3_merge_disjoint", rdata_a[1], 32'h5555aaaa);

    // 4: read-during-write, old data on a, new data on b (latency 2).
    wr(0, 4'd7, 32'h1, 4'hf);
    cyc();
    wr(0, 4'd7, 32'h2, 4'hf);
    rd(1, 4'd7);
    cyc();
    idle();
    check("t4_rdw_old", rdata_a[1], 32'h1);
    check("t4_b_lat_rvalid", 32'(rvalid_b), 32'h0);
    cyc();
    check("t4_rdw_new", rdata_b[1], 32'h2);
    check("t4_b_rvalid", 32'(rvalid_b), 32'h2);

    // 5: pipelined reads through the output register.
    wr(0, 4'd0, 32'ha0a0a0a0, 4'hf);
    cyc();
    wr(0, 4'd1, 32'ha1a1a1a1, 4'hf);
    cyc();
    wr(0, 4'd2, 32'ha2a2a2a2, 4'hf);
    cyc();
    idle();
    rd(1, 4'd0);
    cyc();
    check("t5_rvalid_e1", 32'(rvalid_b), 32'h0);
    check("t5_a_data0", rdata_a[1], 32'ha0a0a0a0);
    rd(1, 4'd1);
    cyc();
    check("t5_rvalid_e2", 32'(rvalid_b), 32'h2);
    check("t5_data0", rdata_b[1], 32'ha0a0a0a0);
    rd(1, 4'd2);
    cyc();
    idle();
    check("t5_rvalid_e3", 32'(rvalid_b), 32'h2);
    check("t5_data1", rdata_b[1], 32'ha1a1a1a1);
    cyc();
    check("t5_rvalid_e4", 32'(rvalid_b), 32'h2);
    check("t5_data2", rdata_b[1], 32'ha2a2a2a2);
    cyc();
    check("t5_rvalid_e5", 32'(rvalid_b), 32'h0);
    check("t5_hold", rdata_b[1], 32'ha2a2a2a2);

    // 6: reset mid-clear with requests active the whole time.
    reset = 1'b1;
    cyc();
    check("t6_reset_rdata", rdata_a[1], 32'h0);
    check("t6_reset_rdata_b", rdata_b[1], 32'h0);
    reset = 1'b0;
    wr(0, 4'd0, 32'hffffffff, 4'hf);
    rd(1, 4'd1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check($sformatf("t6_busy_pre_%0d", i), 32'(busy_a), 32'h1);
      check($sformatf("t6_rvalid_pre_%0d", i), 32'(rvalid_a), 32'h0);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        #3;
      end
      cyc();
      if (i == 15) begin
        // Drop requests before the edge that ends the clear.
        #2;
        idle();
      end
      check($sformatf("t6_busy_%0d", i), 32'(busy_a), (i < 16) ? 32'h1 : 32'h0);
      check($sformatf("t6_rvalid_%0d", i), 32'(rvalid_a | rvalid_b), 32'h0);
    end
    idle();
    rd(0, 4'd0);
    rd(1, 4'd3);
    cyc();
    idle();
    check("t6_addr0_clear", rdata_a[0], 32'h0);
    check("t6_addr3_clear", rdata_a[1], 32'h0);
    check("t6_rvalid_run", 32'(rvalid_a), 32'h3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
